// File: rtl/ex_div_ctrl.sv
// Multi-cycle restoring divider for the EX stage: signed/unsigned, one quotient bit per clock.
// Result is {remainder, quotient}; busy_o stalls the pipeline while an operation is in flight.
module ex_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             quo_neg;
    logic             rem_neg;

    logic             accept;
    logic             iterate;
    logic             finish;
    logic             clear;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign ready_o = (state == END);
    assign busy_o  = (state != FREE);

    // Operand magnitudes and one restoring step; a borrow out of diff means the trial subtract failed.
    always_comb begin
        a_mag    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_mag    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted  = {rem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], qbit};
        q_fin    = quo_neg ? -quo_next : quo_next;
        r_fin    = rem_neg ? -rem_next : rem_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        clear      = 1'b0;
        case (state)
            FREE: begin
                if (start_i && !annul_i) begin
                    accept     = 1'b1;
                    next_state = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                clear      = 1'b1;
                next_state = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    clear      = 1'b1;
                    next_state = FREE;
                end else begin
                    iterate = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        finish     = 1'b1;
                        next_state = END;
                    end
                end
            end
            END: begin
                if (!start_i) begin
                    clear      = 1'b1;
                    next_state = FREE;
                end
            end
            default: next_state = FREE;
        endcase
    end

    // Datapath: operands are captured once at accept so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            result_o <= '0;
        end else begin
            if (accept) begin
                dvd     <= a_mag;
                dvs     <= b_mag;
                rem     <= '0;
                quo     <= '0;
                cnt     <= '0;
                quo_neg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                rem_neg <= signed_div_i & opdata1_i[WIDTH-1];
            end else if (iterate) begin
                dvd <= dvd << 1;
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                result_o <= {r_fin, q_fin};
            end else if (clear) begin
                result_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: expected results are queued at issue and popped when ready_o rises.
module tb_ex_div_ctrl;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [63:0]        sb_q[$];

    ex_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .start_i(start_i),
        .annul_i(annul_i),
        .result_o(result_o),
        .ready_o(ready_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(bit s, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        if (expect_res) sb_q.push_back(model(s, a, b));
    endtask

    // Edges counted from the accept edge (index 0); bounded so a dead DUT cannot hang the run.
    task automatic wait_ready(input bit wiggle, output int lat, output bit timed_out);
        lat       = -1;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) begin
                lat       = i;
                timed_out = 1'b0;
                break;
            end
            if (wiggle) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
                start_i   = 1'($urandom_range(0, 1));
            end
        end
        start_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
        n_checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got ready=%b busy=%b expected 0 0", ready_o, busy_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat; bit to; logic [63:0] exp_v;
        issue(1'b0, 32'd100, 32'd7, 1'b1);
        wait_ready(1'b0, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (lat !== WIDTH) begin n_fail++; $display("[TB] FAIL unsigned_latency: got %0d expected %0d (timeout=%0b)", lat, WIDTH, to); end
        n_checks++;
        if (result_o !== exp_v || result_o !== 64'h00000002_0000000E) begin
            n_fail++; $display("[TB] FAIL unsigned_result: got %h expected %h", result_o, exp_v);
        end
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL end_busy: got %b expected 1", busy_o); end
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (ready_o !== 1'b1 || result_o !== exp_v) begin
            n_fail++; $display("[TB] FAIL end_hold: got ready=%b result=%h expected 1 %h", ready_o, result_o, exp_v);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL end_release: got ready=%b busy=%b result=%h expected 0 0 0", ready_o, busy_o, result_o);
        end
    endtask

    task automatic test_signed();
        int lat; bit to; logic [63:0] exp_v;
        for (int m = 1; m >= 0; m--) begin
            issue(m[0], 32'hFFFF_FFF9, 32'd2, 1'b1);
            wait_ready(1'b0, lat, to);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (to || result_o !== exp_v) begin
                n_fail++; $display("[TB] FAIL signed_mode%0d_result: got %h expected %h (timeout=%0b)", m, result_o, exp_v, to);
            end
            start_i = 1'b0;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_divzero();
        int lat; bit to; logic [63:0] exp_v;
        for (int m = 0; m < 2; m++) begin
            issue(m[0], 32'hFFFF_FFF9, 32'd0, 1'b1);
            wait_ready(1'b0, lat, to);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (lat !== 1) begin n_fail++; $display("[TB] FAIL divzero%0d_latency: got %0d expected 1 (timeout=%0b)", m, lat, to); end
            n_checks++;
            if (result_o !== exp_v || ready_o !== 1'b1) begin
                n_fail++; $display("[TB] FAIL divzero%0d_result: got %h ready=%b expected %h 1", m, result_o, ready_o, exp_v);
            end
            start_i = 1'b0;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_annul();
        int lat; bit to; bit saw_ready; logic [63:0] exp_v;
        saw_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        annul_i = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0 || saw_ready) begin
            n_fail++; $display("[TB] FAIL annul_abort: got busy=%b ready=%b result=%h saw_ready=%b expected 0 0 0 0",
                               busy_o, ready_o, result_o, saw_ready);
        end
        annul_i = 1'b0;
        issue(1'b0, 32'd27, 32'd5, 1'b1);
        wait_ready(1'b0, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (lat !== WIDTH || result_o !== exp_v || result_o !== 64'h00000002_00000005) begin
            n_fail++; $display("[TB] FAIL annul_restart: got lat=%0d result=%h expected %0d %h", lat, result_o, WIDTH, exp_v);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat; bit to; logic [63:0] exp_v;
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (6) begin
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++; $display("[TB] FAIL async_reset: got busy=%b ready=%b result=%h expected 0 0 0", busy_o, ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_ready(1'b0, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (lat !== WIDTH || result_o !== exp_v || result_o !== 64'h00000000_80000000) begin
            n_fail++; $display("[TB] FAIL overflow_after_reset: got lat=%0d result=%h expected %0d %h", lat, result_o, WIDTH, exp_v);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_operand_change();
        int lat; bit to; logic [63:0] exp_v;
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
        wait_ready(1'b1, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (lat !== WIDTH || result_o !== exp_v) begin
            n_fail++; $display("[TB] FAIL wiggle_unsigned: got lat=%0d result=%h expected %0d %h", lat, result_o, WIDTH, exp_v);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        issue(1'b1, 32'h8765_4321, 32'hFFFF_FF03, 1'b1);
        wait_ready(1'b1, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (lat !== WIDTH || result_o !== exp_v) begin
            n_fail++; $display("[TB] FAIL wiggle_signed: got lat=%0d result=%h expected %0d %h", lat, result_o, WIDTH, exp_v);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit to; logic [63:0] exp_v;
        issue(1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        wait_ready(1'b0, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || result_o !== exp_v) begin
            n_fail++; $display("[TB] FAIL b2b_first: got %h expected %h (timeout=%0b)", result_o, exp_v, to);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        issue(1'b0, 32'hFFFF_FFFF, 32'd16, 1'b1);
        wait_ready(1'b0, lat, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (lat !== WIDTH || result_o !== exp_v) begin
            n_fail++; $display("[TB] FAIL b2b_second: got lat=%0d result=%h expected %0d %h", lat, result_o, WIDTH, exp_v);
        end
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL final_idle: got queue=%0d busy=%b expected 0 0", sb_q.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_async_reset();
        test_operand_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
